// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
//    Shared game constants for the shooter: game state codes, screen and
//    sprite sizes, pool limits, and the packed {x,y} position type with the
//    off-screen NONE marker used for empty slots.
//    No ports (package).
// -----------------------------------------------------------------------------
package game_pkg;

   typedef enum logic [2:0] {
      GAME_IDLE    = 3'd0,
      GAME_PLAYING = 3'd1,
      GAME_VICTORY = 3'd2,
      GAME_DEFEAT  = 3'd3,
      GAME_ERROR   = 3'd4
   } game_state_e;

   localparam logic [9:0] MONITOR_WIDTH  = 10'd640;
   localparam logic [8:0] MONITOR_HEIGHT = 9'd480;

   localparam logic [9:0] PLAYER_WIDTH   = 10'd24;
   localparam logic [8:0] PLAYER_HEIGHT  = 9'd16;
   localparam logic [9:0] BULLET_WIDTH   = 10'd4;
   localparam logic [8:0] BULLET_HEIGHT  = 9'd16;

   localparam logic [3:0]  MAX_PLAYER_BULLET   = 4'd15;
   localparam int unsigned PLAYER_BULLET_SLOTS = 16;

   localparam logic [8:0] BULLET_SPEED_DEFAULT    = 9'd4;
   localparam logic [3:0] COOLDOWN_FRAMES_DEFAULT = 4'd8;

   typedef struct packed {
      logic [9:0] x;
      logic [8:0] y;
   } pos_t;

   // Empty slots sit in the off-screen margin so the renderer never draws them.
   localparam pos_t NONE = '{x: 10'd720, y: 9'd500};

endpackage

// File: rtl/bullet_slot_alloc.sv
// -----------------------------------------------------------------------------
// bullet_slot_alloc
//    Combinational lowest-index-first priority encoder over the free-slot
//    vector of the player bullet pool.
//    Ports:
//       i_free   in   16  bit n = slot n is free
//       o_idx    out  4   lowest free slot index (0 when none free)
//       o_found  out  1   at least one slot is free
// -----------------------------------------------------------------------------
module bullet_slot_alloc
   import game_pkg::*;
(
   input  logic [PLAYER_BULLET_SLOTS-1:0] i_free,
   output logic [3:0]                     o_idx,
   output logic                           o_found
);

   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int unsigned i = 0; i < PLAYER_BULLET_SLOTS; i++) begin
         if (i_free[i] && !o_found) begin
            o_idx   = 4'(i);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/player_bullet_pool.sv
// -----------------------------------------------------------------------------
// player_bullet_pool
//    Owns the player's 16 bullet slots. Fire edges request a spawn above the
//    ship; live bullets climb once per frame tick, despawning at the top of
//    the screen or when the collision checker flags a hit.
//    Ports:
//       clk             in   1    system clock
//       rst_n           in   1    synchronous active-low reset
//       i_game_state    in   3    game_state_e code
//       i_frame_tick    in   1    one-cycle pulse per video frame
//       i_fire          in   1    debounced fire button level
//       i_player_x      in   10   player top-left x
//       i_player_y      in   9    player top-left y
//       i_hit_mask      in   16   bit n = slot n collided this cycle
//       o_bullet_pos    out  304  slot n {x,y} at [19n+18:19n]
//       o_bullet_alive  out  16   bit n = slot n live
//       o_shot_fired    out  1    one-cycle pulse on spawn
// -----------------------------------------------------------------------------
module player_bullet_pool
   import game_pkg::*;
#(
   parameter logic [8:0] BULLET_SPEED    = BULLET_SPEED_DEFAULT,
   parameter logic [3:0] COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [2:0]   i_game_state,
   input  logic         i_frame_tick,
   input  logic         i_fire,
   input  logic [9:0]   i_player_x,
   input  logic [8:0]   i_player_y,
   input  logic [15:0]  i_hit_mask,
   output logic [303:0] o_bullet_pos,
   output logic [15:0]  o_bullet_alive,
   output logic         o_shot_fired
);

   localparam logic [9:0] SPAWN_X_OFFSET  = (PLAYER_WIDTH - BULLET_WIDTH) >> 1;
   localparam logic [8:0] DESPAWN_Y_LIMIT = BULLET_SPEED + 9'd1;

   pos_t        pos_q  [PLAYER_BULLET_SLOTS];
   pos_t        pos_d  [PLAYER_BULLET_SLOTS];
   pos_t        pos_mv [PLAYER_BULLET_SLOTS];
   logic [15:0] alive_q, alive_d, alive_mv;
   logic [15:0] free_vec;
   logic [3:0]  cooldown_q, cooldown_d;
   logic        pending_q, pending_d;
   logic        fire_prev_q, fire_prev_d;
   logic        shot_q, shot_d;

   game_state_e state;
   logic        fire_rise;
   logic [3:0]  spawn_idx;
   logic        spawn_found;
   pos_t        spawn_pos;

   always_comb begin
      state       = game_state_e'(i_game_state);
      fire_rise   = i_fire & ~fire_prev_q;
      fire_prev_d = i_fire;
   end

   // Hits and movement first; the allocator then sees slots freed this cycle.
   always_comb begin
      pos_mv   = pos_q;
      alive_mv = alive_q;
      for (int unsigned i = 0; i < PLAYER_BULLET_SLOTS; i++) begin
         if (alive_q[i]) begin
            if (i_hit_mask[i]) begin
               pos_mv[i]   = NONE;
               alive_mv[i] = 1'b0;
            end else if (i_frame_tick) begin
               // Despawn before the subtraction could wrap past the top edge.
               if (pos_q[i].y < DESPAWN_Y_LIMIT) begin
                  pos_mv[i]   = NONE;
                  alive_mv[i] = 1'b0;
               end else begin
                  pos_mv[i].y = pos_q[i].y - BULLET_SPEED;
               end
            end
         end
      end
      free_vec = ~alive_mv;
   end

   bullet_slot_alloc u_alloc (
      .i_free  (free_vec),
      .o_idx   (spawn_idx),
      .o_found (spawn_found)
   );

   always_comb begin
      spawn_pos.x = i_player_x + SPAWN_X_OFFSET;
      spawn_pos.y = (i_player_y < BULLET_HEIGHT) ? '0 : (i_player_y - BULLET_HEIGHT);
   end

   always_comb begin
      pos_d      = pos_q;
      alive_d    = alive_q;
      cooldown_d = cooldown_q;
      pending_d  = pending_q;
      shot_d     = 1'b0;
      case (state)
         GAME_PLAYING: begin
            pos_d   = pos_mv;
            alive_d = alive_mv;
            if (i_frame_tick) begin
               if (cooldown_q != '0) begin
                  cooldown_d = cooldown_q - 4'd1;
               end else if (pending_q) begin
                  // Served or dropped on a full pool; either way the request ends.
                  pending_d = 1'b0;
                  if (spawn_found) begin
                     pos_d[spawn_idx]   = spawn_pos;
                     alive_d[spawn_idx] = 1'b1;
                     cooldown_d         = COOLDOWN_FRAMES;
                     shot_d             = 1'b1;
                  end
               end
            end
            // Applied after the tick so an edge on a tick waits for the next one.
            if (fire_rise) begin
               pending_d = 1'b1;
            end
         end
         GAME_VICTORY, GAME_DEFEAT: begin
         end
         default: begin
            for (int unsigned i = 0; i < PLAYER_BULLET_SLOTS; i++) begin
               pos_d[i] = NONE;
            end
            alive_d    = '0;
            cooldown_d = '0;
            pending_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < PLAYER_BULLET_SLOTS; i++) begin
            pos_q[i] <= NONE;
         end
         alive_q     <= '0;
         cooldown_q  <= '0;
         pending_q   <= 1'b0;
         fire_prev_q <= 1'b0;
         shot_q      <= 1'b0;
      end else begin
         pos_q       <= pos_d;
         alive_q     <= alive_d;
         cooldown_q  <= cooldown_d;
         pending_q   <= pending_d;
         fire_prev_q <= fire_prev_d;
         shot_q      <= shot_d;
      end
   end

   always_comb begin
      o_bullet_pos = '0;
      for (int unsigned i = 0; i < PLAYER_BULLET_SLOTS; i++) begin
         o_bullet_pos[19*i +: 19] = pos_q[i];
      end
      o_bullet_alive = alive_q;
      o_shot_fired   = shot_q;
   end

endmodule
